usb_txn_ctrl: RTL and testbench
===============================

Name: usb_txn_ctrl

Overview:
- Host-side transaction controller that sits directly upstream of pipeOut and directly downstream of pipeIn.
- Turns a single OUT (write) or IN (read) request into the USB packet sequence (token, DATA0, handshake), with response timeout and bounded retry.
- Drives pipeOut's pid/endp/addr/data/pktready_bs fields; consumes pipeIn's pktready/error/ack/nak/data.

Parameters:
TIMEOUT, 255, cycles to wait for a device response after our last packet finishes transmitting
MAX_RETRY, 8, total attempts before a transaction is declared failed

Ports:
clk  in  1  system clock
rst_L  in  1  synchronous active-low reset
start_out  in  1  1-cycle pulse: begin OUT transaction (sampled only in IDLE)
start_in  in  1  1-cycle pulse: begin IN transaction (sampled only in IDLE; start_out wins if both high)
req_addr  in  7  device address, latched at start
req_endp  in  4  endpoint, latched at start
req_data  in  64  OUT payload, latched at start
rd_data  out  64  IN payload, valid with done & success
done  out  1  1-cycle pulse at transaction end
success  out  1  valid with done; 1 = ACK/valid data, 0 = retries exhausted
busy  out  1  high whenever state != IDLE
tx_pid  out  4  to pipeOut pid
tx_endp  out  4  to pipeOut endp
tx_addr  out  7  to pipeOut addr
tx_data  out  64  to pipeOut data
tx_pktready  out  1  to pipeOut pktready_bs, 1-cycle pulse
tx_done  in  1  1-cycle pulse from pipeOut when EOP has been driven
rx_pktready  in  1  from pipeIn pktready
rx_error  in  1  from pipeIn error (CRC/PID/stuff error), qualified by rx_pktready
rx_ack  in  1  from pipeIn ack
rx_nak  in  1  from pipeIn nak
rx_data  in  64  from pipeIn data

Behaviour:
- PIDs: OUT=4'b0001, IN=4'b1001, DATA0=4'b0011, ACK=4'b0010, NAK=4'b1010.
- Reset: state IDLE; all outputs 0; retry counter and timer cleared. Reset mid-transaction aborts with no done pulse.
- tx_* fields are registered, set in the same cycle as tx_pktready, and held stable until tx_done. No new tx_pktready is issued before tx_done of the previous packet.
- States:
  IDLE -> TOKEN on start; latch req_*; clear attempt count.
  TOKEN: pulse tx_pktready with pid OUT/IN. On tx_done: OUT -> DATA; IN -> WAIT_DATA.
  DATA: pulse tx_pktready with pid DATA0 and latched payload. On tx_done -> WAIT_HS.
  WAIT_HS: rx_ack -> FIN (success). rx_nak, rx_error, or timer == TIMEOUT -> RETRY.
  WAIT_DATA: rx_pktready & ~rx_error -> capture rx_data into rd_data, go to SEND_ACK. rx_pktready & rx_error -> SEND_NAK. rx_nak or timeout -> RETRY.
  SEND_ACK: pulse pid ACK. On tx_done -> FIN (success).
  SEND_NAK: pulse pid NAK. On tx_done -> RETRY.
  RETRY: attempts+1. If attempts+1 == MAX_RETRY -> FIN (fail); else -> TOKEN.
  FIN: done=1 for one cycle with success; -> IDLE.
- Timer: cleared on entry to WAIT_HS/WAIT_DATA and increments each cycle there. Timeout fires on the cycle the count equals TIMEOUT (TIMEOUT+1 cycles after entry). A response on that same cycle wins over timeout.
- Simultaneous rx_ack & rx_nak: treated as NAK. rx_* outside the WAIT states are ignored.
- Attempt counter width: $clog2(MAX_RETRY+1). Exactly MAX_RETRY token transmissions on total failure.
- rd_data holds its value until the next successful IN.

Optional Feature:
USB_TXN_STATS_EN
- Defined: adds output retry_total [15:0], a saturating count of RETRY-state entries since reset (sticks at 16'hFFFF), and output last_fail_timeout [0:0], set at a failed FIN if the final attempt ended by timeout.
- Undefined: these ports and registers do not exist.

Decomposition:
- usb_pkg holds the pid_t enum (values above), the txn_state_t enum, and the DEFAULT_TIMEOUT/DEFAULT_MAX_RETRY constants. pipeOut/pipeIn users import the same pid_t.
- One sub-module, usb_resp_timer: counter with clear/enable and an expired flag at TIMEOUT, parameterised by TIMEOUT.

Test Plan:
- OUT, addr 7'h05, endp 4'h4, data 64'hDEADBEEF_CAFEF00D; device ACKs 10 cycles after the DATA tx_done -> packets OUT then DATA0 with the exact fields; done=1, success=1; busy low the next cycle.
- IN, valid rx_data 64'h0123_4567_89AB_CDEF -> ACK packet sent; done with success=1 after the ACK's tx_done; rd_data equals the value.
- IN, rx_error on the first reply, clean reply on the second -> one NAK packet, two IN tokens, success=1.
- OUT, no response ever, TIMEOUT=255, MAX_RETRY=8 -> 8 OUT+DATA0 pairs; each wait is exactly 256 cycles; done with success=0.
- OUT, device NAKs 3 times then ACKs -> 4 token pairs, success=1; with USB_TXN_STATS_EN, retry_total=3.
- Reset asserted during WAIT_HS -> next cycle all outputs 0, no done; a new start_in proceeds normally.

Source files
------------

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB PID encodings, transaction FSM states and defaults
// Contents:
//   pid_t        - 4-bit packet identifiers shared with pipeOut/pipeIn users
//   txn_state_t  - usb_txn_ctrl transaction FSM states
//   DEFAULT_TIMEOUT / DEFAULT_MAX_RETRY - default response window and attempt budget
package usb_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010
    } pid_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TOKEN,
        ST_DATA,
        ST_WAIT_HS,
        ST_WAIT_DATA,
        ST_SEND_ACK,
        ST_SEND_NAK,
        ST_RETRY,
        ST_FIN
    } txn_state_t;

    localparam int DEFAULT_TIMEOUT   = 255;
    localparam int DEFAULT_MAX_RETRY = 8;

endpackage

// File: rtl/usb_resp_timer.sv
// rtl/usb_resp_timer.sv - device response window counter with clear/enable and expiry flag
// Ports:
//   clk, rst_L - clock, synchronous active-low reset
//   clear      - forces the count to zero (takes priority over enable)
//   enable     - count up one per cycle while set
//   expired    - high while the count equals TIMEOUT
module usb_resp_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_L,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    assign expired = (count == W'(TIMEOUT));

    // Holds at TIMEOUT so a stalled caller never sees the count wrap back to zero.
    always_ff @(posedge clk) begin
        if (!rst_L || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/usb_txn_ctrl.sv
// rtl/usb_txn_ctrl.sv - host USB transaction controller: token/DATA0/handshake sequencing with timeout and retry
// Optional build macro: USB_TXN_STATS_EN adds retry_total[15:0] and last_fail_timeout outputs.
// Ports:
//   clk, rst_L                    - clock, synchronous active-low reset
//   start_out, start_in           - one-cycle transaction requests (OUT has priority), sampled in IDLE
//   req_addr/req_endp/req_data    - request fields, latched at start
//   rd_data                       - IN payload, updated only on a successful IN
//   done, success, busy           - completion pulse, result, activity flag
//   tx_pid/endp/addr/data         - packet fields to pipeOut, held until tx_done
//   tx_pktready, tx_done          - pipeOut launch pulse / end-of-packet pulse
//   rx_pktready/error/ack/nak/data- pipeIn receive status and payload
module usb_txn_ctrl
    import usb_pkg::*;
#(
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int MAX_RETRY = DEFAULT_MAX_RETRY
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        start_out,
    input  logic        start_in,
    input  logic [6:0]  req_addr,
    input  logic [3:0]  req_endp,
    input  logic [63:0] req_data,
    output logic [63:0] rd_data,
    output logic        done,
    output logic        success,
    output logic        busy,
    output logic [3:0]  tx_pid,
    output logic [3:0]  tx_endp,
    output logic [6:0]  tx_addr,
    output logic [63:0] tx_data,
    output logic        tx_pktready,
    input  logic        tx_done,
    input  logic        rx_pktready,
    input  logic        rx_error,
    input  logic        rx_ack,
    input  logic        rx_nak,
    input  logic [63:0] rx_data
`ifdef USB_TXN_STATS_EN
    ,
    output logic [15:0] retry_total,
    output logic        last_fail_timeout
`endif
);

    localparam int AW = $clog2(MAX_RETRY + 1);

    txn_state_t  state, state_n;
    logic [AW-1:0] attempts;
    logic [AW-1:0] attempts_inc;
    logic        lat_out;
    logic [6:0]  lat_addr;
    logic [3:0]  lat_endp;
    logic [63:0] lat_data;
    logic        tx_pending;
    logic        success_r, success_n;
    logic        in_wait, in_tx, issue, pkt_done, expired, start_any, last_try;
    pid_t        issue_pid;

    assign start_any    = start_out | start_in;
    assign in_wait      = (state == ST_WAIT_HS) || (state == ST_WAIT_DATA);
    assign in_tx        = (state == ST_TOKEN) || (state == ST_DATA) ||
                          (state == ST_SEND_ACK) || (state == ST_SEND_NAK);
    // One launch per packet state; tx_pending blocks a relaunch until pipeOut reports EOP.
    assign issue        = in_tx && !tx_pending;
    assign pkt_done     = tx_pending && tx_done;
    assign attempts_inc = attempts + 1'b1;
    assign last_try     = (attempts_inc == AW'(MAX_RETRY));

    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_FIN);
    assign success = done && success_r;

    usb_resp_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_L   (rst_L),
        .clear   (!in_wait),
        .enable  (in_wait),
        .expired (expired)
    );

    always_comb begin
        issue_pid = PID_OUT;
        case (state)
            ST_TOKEN:    issue_pid = lat_out ? PID_OUT : PID_IN;
            ST_DATA:     issue_pid = PID_DATA0;
            ST_SEND_ACK: issue_pid = PID_ACK;
            ST_SEND_NAK: issue_pid = PID_NAK;
            default:     issue_pid = PID_OUT;
        endcase
    end

    always_comb begin
        state_n   = state;
        success_n = success_r;
        case (state)
            ST_IDLE: begin
                if (start_any) begin
                    state_n   = ST_TOKEN;
                    success_n = 1'b0;
                end
            end
            ST_TOKEN: begin
                if (pkt_done) state_n = lat_out ? ST_DATA : ST_WAIT_DATA;
            end
            ST_DATA: begin
                if (pkt_done) state_n = ST_WAIT_HS;
            end
            ST_WAIT_HS: begin
                // NAK is checked first so ACK+NAK together counts as a NAK.
                if (rx_nak || (rx_pktready && rx_error)) begin
                    state_n = ST_RETRY;
                end else if (rx_ack) begin
                    state_n   = ST_FIN;
                    success_n = 1'b1;
                end else if (expired) begin
                    state_n = ST_RETRY;
                end
            end
            ST_WAIT_DATA: begin
                if (rx_pktready) begin
                    state_n = rx_error ? ST_SEND_NAK : ST_SEND_ACK;
                end else if (rx_nak || expired) begin
                    state_n = ST_RETRY;
                end
            end
            ST_SEND_ACK: begin
                if (pkt_done) begin
                    state_n   = ST_FIN;
                    success_n = 1'b1;
                end
            end
            ST_SEND_NAK: begin
                if (pkt_done) state_n = ST_RETRY;
            end
            ST_RETRY: begin
                if (last_try) begin
                    state_n   = ST_FIN;
                    success_n = 1'b0;
                end else begin
                    state_n = ST_TOKEN;
                end
            end
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state       <= ST_IDLE;
            success_r   <= 1'b0;
            attempts    <= '0;
            lat_out     <= 1'b0;
            lat_addr    <= '0;
            lat_endp    <= '0;
            lat_data    <= '0;
            tx_pending  <= 1'b0;
            tx_pktready <= 1'b0;
            tx_pid      <= '0;
            tx_addr     <= '0;
            tx_endp     <= '0;
            tx_data     <= '0;
            rd_data     <= '0;
        end else begin
            state     <= state_n;
            success_r <= success_n;

            if (state == ST_IDLE && start_any) begin
                lat_out  <= start_out;
                lat_addr <= req_addr;
                lat_endp <= req_endp;
                lat_data <= req_data;
                attempts <= '0;
            end else if (state == ST_RETRY) begin
                attempts <= attempts_inc;
            end

            tx_pktready <= issue;
            if (issue) begin
                tx_pid     <= issue_pid;
                tx_addr    <= lat_addr;
                tx_endp    <= lat_endp;
                tx_data    <= lat_data;
                tx_pending <= 1'b1;
            end else if (pkt_done) begin
                tx_pending <= 1'b0;
            end

            // A clean IN reply always ends in success, so capture here is safe.
            if (state == ST_WAIT_DATA && rx_pktready && !rx_error) begin
                rd_data <= rx_data;
            end
        end
    end

`ifdef USB_TXN_STATS_EN
    logic last_to;
    logic timeout_end;

    // True when the wait state is leaving for RETRY only because the window closed.
    assign timeout_end = expired &&
        ((state == ST_WAIT_HS && !rx_nak && !(rx_pktready && rx_error) && !rx_ack) ||
         (state == ST_WAIT_DATA && !rx_pktready && !rx_nak));

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            retry_total       <= '0;
            last_fail_timeout <= 1'b0;
            last_to           <= 1'b0;
        end else begin
            if (state == ST_RETRY && retry_total != 16'hFFFF) begin
                retry_total <= retry_total + 16'd1;
            end
            if (state_n == ST_RETRY && state != ST_RETRY) begin
                last_to <= timeout_end;
            end
            if (state == ST_IDLE && start_any) begin
                last_fail_timeout <= 1'b0;
            end else if (state == ST_RETRY && last_try) begin
                last_fail_timeout <= last_to;
            end
        end
    end
`endif

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// tb/tb_usb_txn_ctrl.sv - directed scoreboard bench for usb_txn_ctrl
module tb_usb_txn_ctrl;
    import usb_pkg::*;

    localparam int TO     = 255;
    localparam int MR     = 8;
    localparam int BUDGET = 600;

    logic        clk;
    logic        rst_L;
    logic        start_out, start_in;
    logic [6:0]  req_addr;
    logic [3:0]  req_endp;
    logic [63:0] req_data;
    logic [63:0] rd_data;
    logic        done, success, busy;
    logic [3:0]  tx_pid, tx_endp;
    logic [6:0]  tx_addr;
    logic [63:0] tx_data;
    logic        tx_pktready, tx_done;
    logic        rx_pktready, rx_error, rx_ack, rx_nak;
    logic [63:0] rx_data;
`ifdef USB_TXN_STATS_EN
    logic [15:0] retry_total;
    logic        last_fail_timeout;
`endif

    typedef struct {
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [63:0] data;
        bit          chk_tok;
        bit          chk_data;
    } pkt_t;

    pkt_t exp_q[$];
    int   vectors;
    int   miscompares;
    int   cyc;
    int   pkt_cyc;
    int   done_cyc;
    int   prev_cyc;
    int   done_cnt;

    usb_txn_ctrl #(.TIMEOUT(TO), .MAX_RETRY(MR)) dut (
        .clk         (clk),
        .rst_L       (rst_L),
        .start_out   (start_out),
        .start_in    (start_in),
        .req_addr    (req_addr),
        .req_endp    (req_endp),
        .req_data    (req_data),
        .rd_data     (rd_data),
        .done        (done),
        .success     (success),
        .busy        (busy),
        .tx_pid      (tx_pid),
        .tx_endp     (tx_endp),
        .tx_addr     (tx_addr),
        .tx_data     (tx_data),
        .tx_pktready (tx_pktready),
        .tx_done     (tx_done),
        .rx_pktready (rx_pktready),
        .rx_error    (rx_error),
        .rx_ack      (rx_ack),
        .rx_nak      (rx_nak),
        .rx_data     (rx_data)
`ifdef USB_TXN_STATS_EN
        ,
        .retry_total       (retry_total),
        .last_fail_timeout (last_fail_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input logic [3:0] pid, input logic [6:0] a, input logic [3:0] e,
                            input logic [63:0] d, input bit ct, input bit cd);
        pkt_t p;
        p.pid = pid; p.addr = a; p.endp = e; p.data = d; p.chk_tok = ct; p.chk_data = cd;
        exp_q.push_back(p);
    endtask

    task automatic chk_idle(input string pfx);
        chk({pfx, "_busy"}, busy, 1'b0);
        chk({pfx, "_done"}, done, 1'b0);
        chk({pfx, "_success"}, success, 1'b0);
        chk({pfx, "_pktready"}, tx_pktready, 1'b0);
        chk({pfx, "_fields"}, {tx_pid, tx_endp, tx_addr}, 15'd0);
        chk({pfx, "_txdata"}, tx_data, 64'd0);
        chk({pfx, "_rddata"}, rd_data, 64'd0);
    endtask

    task automatic start_txn(input bit is_out, input logic [6:0] a, input logic [3:0] e,
                             input logic [63:0] d);
        @(negedge clk);
        start_out = is_out; start_in = !is_out;
        req_addr = a; req_endp = e; req_data = d;
        @(negedge clk);
        start_out = 1'b0; start_in = 1'b0;
        req_data = 64'd0;
    endtask

    // Wait for a launch, check it against the scoreboard, then play pipeOut's EOP.
    task automatic wait_pkt(input int dly);
        int   n;
        pkt_t e;
        n = 0;
        while (!tx_pktready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("pkt_seen", tx_pktready, 1'b1);
        if (!tx_pktready) return;
        pkt_cyc = cyc;
        if (exp_q.size() == 0) begin
            chk("pkt_unexpected", exp_q.size(), 1);
            return;
        end
        e = exp_q.pop_front();
        chk("pkt_pid", tx_pid, e.pid);
        if (e.chk_tok) begin
            chk("pkt_addr", tx_addr, e.addr);
            chk("pkt_endp", tx_endp, e.endp);
        end
        if (e.chk_data) chk("pkt_data", tx_data, e.data);
        @(negedge clk);
        chk("pktready_pulse", tx_pktready, 1'b0);
        repeat (dly) begin
            @(negedge clk);
            chk("pkt_no_relaunch", tx_pktready, 1'b0);
        end
        chk("pkt_pid_hold", tx_pid, e.pid);
        tx_done  = 1'b1;
        done_cyc = cyc;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic rx_pulse(input bit ack, input bit nak, input bit pr, input bit err,
                            input logic [63:0] d, input int dly);
        repeat (dly) @(negedge clk);
        rx_ack = ack; rx_nak = nak; rx_pktready = pr; rx_error = err; rx_data = d;
        @(negedge clk);
        rx_ack = 1'b0; rx_nak = 1'b0; rx_pktready = 1'b0; rx_error = 1'b0; rx_data = 64'd0;
    endtask

    task automatic wait_done(input logic exp_succ);
        int n;
        n = 0;
        while (!done && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1'b1);
        chk("done_success", success, exp_succ);
        @(negedge clk);
        chk("busy_after_done", busy, 1'b0);
        chk("done_one_cycle", done, 1'b0);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_L = 1'b0; start_out = 1'b0; start_in = 1'b0;
        req_addr = '0; req_endp = '0; req_data = '0;
        tx_done = 1'b0; rx_pktready = 1'b0; rx_error = 1'b0;
        rx_ack = 1'b0; rx_nak = 1'b0; rx_data = '0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_L = 1'b1;

        // OUT with ACK 10 cycles after the DATA0 EOP
        push_pkt(PID_OUT, 7'h05, 4'h4, 64'd0, 1, 0);
        push_pkt(PID_DATA0, 7'h05, 4'h4, 64'hDEADBEEF_CAFEF00D, 0, 1);
        start_txn(1, 7'h05, 4'h4, 64'hDEADBEEF_CAFEF00D);
        chk("out_busy", busy, 1'b1);
        wait_pkt(2);
        wait_pkt(3);
        rx_pulse(1, 0, 0, 0, 64'd0, 9);
        wait_done(1'b1);

        // IN with a clean reply
        push_pkt(PID_IN, 7'h12, 4'h3, 64'd0, 1, 0);
        push_pkt(PID_ACK, 7'h00, 4'h0, 64'd0, 0, 0);
        start_txn(0, 7'h12, 4'h3, 64'd0);
        wait_pkt(2);
        rx_pulse(0, 0, 1, 0, 64'h0123_4567_89AB_CDEF, 4);
        wait_pkt(2);
        wait_done(1'b1);
        chk("in_rd_data", rd_data, 64'h0123_4567_89AB_CDEF);

        // IN: corrupted first reply, clean second reply
        push_pkt(PID_IN, 7'h21, 4'h7, 64'd0, 1, 0);
        push_pkt(PID_NAK, 7'h00, 4'h0, 64'd0, 0, 0);
        push_pkt(PID_IN, 7'h21, 4'h7, 64'd0, 1, 0);
        push_pkt(PID_ACK, 7'h00, 4'h0, 64'd0, 0, 0);
        start_txn(0, 7'h21, 4'h7, 64'd0);
        wait_pkt(1);
        rx_pulse(0, 0, 1, 1, 64'h1111_2222_3333_4444, 2);
        wait_pkt(1);
        chk("inerr_rd_hold", rd_data, 64'h0123_4567_89AB_CDEF);
        wait_pkt(1);
        rx_pulse(0, 0, 1, 0, 64'hFEDC_BA98_7654_3210, 3);
        wait_pkt(1);
        wait_done(1'b1);
        chk("inerr_rd_data", rd_data, 64'hFEDC_BA98_7654_3210);

        // OUT with no response: MR attempts, each window TO+1 cycles
        for (int i = 0; i < MR; i++) begin
            push_pkt(PID_OUT, 7'h40, 4'h9, 64'd0, 1, 0);
            push_pkt(PID_DATA0, 7'h40, 4'h9, 64'h5555_AAAA_0000_FFFF, 0, 1);
        end
        start_txn(1, 7'h40, 4'h9, 64'h5555_AAAA_0000_FFFF);
        for (int i = 0; i < MR; i++) begin
            prev_cyc = done_cyc;
            wait_pkt(0);
            // window of TO+1 cycles, then RETRY, TOKEN, registered launch
            if (i > 0) chk("retry_token_gap", pkt_cyc - prev_cyc, TO + 1 + 3);
            wait_pkt(0);
        end
        prev_cyc = done_cyc;
        while (!done && (cyc - prev_cyc) < BUDGET) @(negedge clk);
        // window of TO+1 cycles, then RETRY, then FIN
        chk("fail_done_gap", cyc - prev_cyc, TO + 1 + 2);
        wait_done(1'b0);
`ifdef USB_TXN_STATS_EN
        chk("stats_last_fail_timeout", last_fail_timeout, 1'b1);
        chk("stats_retry_total_pre", retry_total, 16'd9);
`endif

        // Reset during WAIT_HS, then a normal IN
        push_pkt(PID_OUT, 7'h33, 4'h2, 64'd0, 1, 0);
        push_pkt(PID_DATA0, 7'h33, 4'h2, 64'h0BAD_F00D_0BAD_F00D, 0, 1);
        start_txn(1, 7'h33, 4'h2, 64'h0BAD_F00D_0BAD_F00D);
        wait_pkt(1);
        wait_pkt(1);
        repeat (20) @(negedge clk);
        rst_L = 1'b0;
        @(negedge clk);
        chk_idle("midrst");
        rst_L = 1'b1;
        done_cnt = 0;
        repeat (TO + 20) begin
            @(negedge clk);
            if (done || busy || tx_pktready) done_cnt++;
        end
        chk("midrst_quiet", done_cnt, 0);
        push_pkt(PID_IN, 7'h11, 4'h1, 64'd0, 1, 0);
        push_pkt(PID_ACK, 7'h00, 4'h0, 64'd0, 0, 0);
        start_txn(0, 7'h11, 4'h1, 64'd0);
        wait_pkt(2);
        rx_pulse(0, 0, 1, 0, 64'hA5A5_5A5A_C3C3_3C3C, 6);
        wait_pkt(2);
        wait_done(1'b1);
        chk("postrst_rd_data", rd_data, 64'hA5A5_5A5A_C3C3_3C3C);

        // OUT: three NAKs (one with ACK also high) then ACK
        for (int i = 0; i < 4; i++) begin
            push_pkt(PID_OUT, 7'h7F, 4'hF, 64'd0, 1, 0);
            push_pkt(PID_DATA0, 7'h7F, 4'hF, 64'h8000_0000_0000_0001, 0, 1);
        end
        start_txn(1, 7'h7F, 4'hF, 64'h8000_0000_0000_0001);
        for (int i = 0; i < 4; i++) begin
            wait_pkt(1);
            wait_pkt(1);
            if (i < 3) rx_pulse((i == 1), 1, 0, 0, 64'd0, 5);
            else       rx_pulse(1, 0, 0, 0, 64'd0, 5);
        end
        wait_done(1'b1);
`ifdef USB_TXN_STATS_EN
        chk("stats_retry_total", retry_total, 16'd3);
        chk("stats_last_fail_clear", last_fail_timeout, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
